// File: rtl/single_cycle_mips_cpu_pkg.sv
// Shared constants for the single-cycle 16-bit MIPS-style CPU: opcodes, funct codes,
// ALU operation codes and instruction field positions.
package single_cycle_mips_cpu_pkg;

    localparam int unsigned ImemDepth = 1024;
    localparam int unsigned DmemDepth = 1024;
    localparam int unsigned NumRegs   = 16;

    localparam int unsigned OpcodeMsb = 31;
    localparam int unsigned OpcodeLsb = 26;
    localparam int unsigned RsMsb     = 25;
    localparam int unsigned RsLsb     = 22;
    localparam int unsigned RtMsb     = 21;
    localparam int unsigned RtLsb     = 18;
    localparam int unsigned RdMsb     = 17;
    localparam int unsigned RdLsb     = 14;
    localparam int unsigned ImmMsb    = 15;
    localparam int unsigned FunctMsb  = 5;
    localparam int unsigned TargetMsb = 9;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpLi    = 6'b001111;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;
    localparam logic [5:0] FnJr  = 6'b001000;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b100;

    localparam logic [3:0] LinkReg = 4'd15;

endpackage

// File: rtl/single_cycle_mips_cpu_alu.sv
// 16-bit ALU: add, sub, and, or, signed set-less-than; unused op codes yield zero.
module single_cycle_mips_cpu_alu
    import single_cycle_mips_cpu_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [2:0]  op_i,
    output logic [15:0] res_o,
    output logic        zero_o
);

    always_comb begin
        res_o = '0;
        case (op_i)
            AluAdd:  res_o = a_i + b_i;
            AluSub:  res_o = a_i - b_i;
            AluAnd:  res_o = a_i & b_i;
            AluOr:   res_o = a_i | b_i;
            AluSlt:  res_o = {15'b0, $signed(a_i) < $signed(b_i)};
            default: res_o = '0;
        endcase
    end

    assign zero_o = (res_o == 16'h0000);

endmodule

// File: rtl/single_cycle_mips_cpu_control.sv
// Instruction decoder: opcode/funct to datapath control signals and ALU operation.
module single_cycle_mips_cpu_control
    import single_cycle_mips_cpu_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       mem_write_o,
    output logic       mem_to_reg_o,
    output logic       branch_o,
    output logic       branch_not_o,
    output logic       jump_and_link_o,
    output logic       jump_reg_o,
    output logic       jump_o,
    output logic       alu_src_o,
    output logic       load_imm_o,
    output logic [2:0] alu_op_o
);

    always_comb begin
        reg_dst_o       = 1'b0;
        reg_write_o     = 1'b0;
        mem_write_o     = 1'b0;
        mem_to_reg_o    = 1'b0;
        branch_o        = 1'b0;
        branch_not_o    = 1'b0;
        jump_and_link_o = 1'b0;
        jump_reg_o      = 1'b0;
        jump_o          = 1'b0;
        alu_src_o       = 1'b0;
        load_imm_o      = 1'b0;
        alu_op_o        = AluAdd;
        case (opcode_i)
            OpRtype: begin
                reg_dst_o = 1'b1;
                case (funct_i)
                    FnAdd: begin reg_write_o = 1'b1; alu_op_o = AluAdd; end
                    FnSub: begin reg_write_o = 1'b1; alu_op_o = AluSub; end
                    FnAnd: begin reg_write_o = 1'b1; alu_op_o = AluAnd; end
                    FnOr:  begin reg_write_o = 1'b1; alu_op_o = AluOr;  end
                    FnSlt: begin reg_write_o = 1'b1; alu_op_o = AluSlt; end
                    FnJr:  jump_reg_o = 1'b1;
                    default: ;
                endcase
            end
            OpAddi: begin reg_write_o = 1'b1; alu_src_o = 1'b1; alu_op_o = AluAdd; end
            OpAndi: begin reg_write_o = 1'b1; alu_src_o = 1'b1; alu_op_o = AluAnd; end
            OpOri:  begin reg_write_o = 1'b1; alu_src_o = 1'b1; alu_op_o = AluOr;  end
            OpSlti: begin reg_write_o = 1'b1; alu_src_o = 1'b1; alu_op_o = AluSlt; end
            OpLw: begin
                reg_write_o  = 1'b1;
                alu_src_o    = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            OpSw: begin mem_write_o = 1'b1; alu_src_o = 1'b1; end
            OpLi: begin reg_write_o = 1'b1; load_imm_o = 1'b1; end
            OpBeq: begin branch_o = 1'b1; alu_op_o = AluSub; end
            OpBne: begin branch_not_o = 1'b1; alu_op_o = AluSub; end
            OpJ:   jump_o = 1'b1;
            OpJal: begin jump_o = 1'b1; jump_and_link_o = 1'b1; reg_write_o = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/single_cycle_mips_cpu_dmem.sv
// Data memory: 1024 x 16-bit, combinational read, write on rising edge. Never cleared.
module single_cycle_mips_cpu_dmem (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [9:0]  addr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o
);

    logic [15:0] memory [0:1023];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            memory[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = memory[addr_i];

endmodule

// File: rtl/single_cycle_mips_cpu_imem.sv
// Instruction memory with combinational read; the load port allows in-system programming.
module single_cycle_mips_cpu_imem (
    input  logic        clk_i,
    input  logic        load_en_i,
    input  logic [9:0]  load_addr_i,
    input  logic [31:0] load_data_i,
    input  logic [9:0]  addr_i,
    output logic [31:0] data_o
);

    logic [31:0] memory [0:1023];

    always_ff @(posedge clk_i) begin
        if (load_en_i) begin
            memory[load_addr_i] <= load_data_i;
        end
    end

    assign data_o = memory[addr_i];

endmodule

// File: rtl/single_cycle_mips_cpu_regfile.sv
// 16 x 16-bit register file, two combinational reads, one write; register 0 is hardwired zero.
module single_cycle_mips_cpu_regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  raddr1_i,
    input  logic [3:0]  raddr2_i,
    output logic [15:0] rdata1_o,
    output logic [15:0] rdata2_o,
    input  logic        we_i,
    input  logic [3:0]  waddr_i,
    input  logic [15:0] wdata_i
);

    logic [15:0] registers [0:15];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) begin
                registers[i] <= '0;
            end
        end else if (we_i && waddr_i != 4'd0) begin
            registers[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 4'd0) ? 16'h0000 : registers[raddr1_i];
    assign rdata2_o = (raddr2_i == 4'd0) ? 16'h0000 : registers[raddr2_i];

endmodule

// File: rtl/single_cycle_mips_cpu.sv
// Single-cycle 16-bit MIPS-style CPU top: fetch, decode, execute, memory and write-back
// all complete within one clock.
module single_cycle_mips_cpu
    import single_cycle_mips_cpu_pkg::*;
(
    input logic clock,
    input logic reset
);

    logic [9:0]  pc, pc_next, pc_plus1, branch_target, jump_target;
    logic [31:0] instruction;
    logic [5:0]  opcode, funct;
    logic [15:0] imm;
    logic        regDst, regWrite, memWrite, memToReg, branch, branchNot;
    logic        jumpAndLink, jumpReg, jump, aluSrc, loadImm;
    logic [2:0]  aluOp;
    logic [15:0] alu_a, alu_b, alu_res;
    logic        alu_zero;
    logic [3:0]  read_reg1, read_reg2, write_reg;
    logic [15:0] read_data1, read_data2, write_back, mem_read_data;
    logic        branch_taken;

    assign opcode      = instruction[OpcodeMsb:OpcodeLsb];
    assign read_reg1   = instruction[RsMsb:RsLsb];
    assign read_reg2   = instruction[RtMsb:RtLsb];
    assign imm         = instruction[ImmMsb:0];
    assign funct       = instruction[FunctMsb:0];
    assign jump_target = instruction[TargetMsb:0];

    single_cycle_mips_cpu_imem inst_mem (
        .clk_i       (clock),
        .load_en_i   (1'b0),
        .load_addr_i (10'd0),
        .load_data_i (32'd0),
        .addr_i      (pc),
        .data_o      (instruction)
    );

    single_cycle_mips_cpu_control control_unit (
        .opcode_i        (opcode),
        .funct_i         (funct),
        .reg_dst_o       (regDst),
        .reg_write_o     (regWrite),
        .mem_write_o     (memWrite),
        .mem_to_reg_o    (memToReg),
        .branch_o        (branch),
        .branch_not_o    (branchNot),
        .jump_and_link_o (jumpAndLink),
        .jump_reg_o      (jumpReg),
        .jump_o          (jump),
        .alu_src_o       (aluSrc),
        .load_imm_o      (loadImm),
        .alu_op_o        (aluOp)
    );

    assign write_reg = jumpAndLink ? LinkReg :
                       regDst      ? instruction[RdMsb:RdLsb] : read_reg2;

    single_cycle_mips_cpu_regfile regs (
        .clk_i    (clock),
        .rst_i    (reset),
        .raddr1_i (read_reg1),
        .raddr2_i (read_reg2),
        .rdata1_o (read_data1),
        .rdata2_o (read_data2),
        .we_i     (regWrite),
        .waddr_i  (write_reg),
        .wdata_i  (write_back)
    );

    assign alu_a = read_data1;
    assign alu_b = aluSrc ? imm : read_data2;

    single_cycle_mips_cpu_alu alu16 (
        .a_i    (alu_a),
        .b_i    (alu_b),
        .op_i   (aluOp),
        .res_o  (alu_res),
        .zero_o (alu_zero)
    );

    single_cycle_mips_cpu_dmem data_mem (
        .clk_i   (clock),
        .we_i    (memWrite),
        .addr_i  (alu_res[9:0]),
        .wdata_i (read_data2),
        .rdata_o (mem_read_data)
    );

    always_comb begin
        if (jumpAndLink) begin
            write_back = {6'b0, pc_plus1};
        end else if (loadImm) begin
            write_back = imm;
        end else if (memToReg) begin
            write_back = mem_read_data;
        end else begin
            write_back = alu_res;
        end
    end

    // pc arithmetic is 10 bits wide so it wraps modulo the instruction memory depth.
    assign pc_plus1      = pc + 10'd1;
    assign branch_target = pc_plus1 + imm[9:0];
    assign branch_taken  = (branch && alu_zero) || (branchNot && !alu_zero);

    always_comb begin
        if (jumpReg) begin
            pc_next = read_data1[9:0];
        end else if (jump) begin
            pc_next = jump_target;
        end else if (branch_taken) begin
            pc_next = branch_target;
        end else begin
            pc_next = pc_plus1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_single_cycle_mips_cpu.sv
// Directed bench for the single-cycle CPU: small programs are written into instruction
// memory and architectural state is compared against hand-computed values.
module tb_single_cycle_mips_cpu;

    logic clock;
    logic reset;

    int checks = 0;
    int errors = 0;

    single_cycle_mips_cpu dut (
        .clock (clock),
        .reset (reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [3:0] rs, input logic [3:0] rt,
                                          input logic [3:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 8'b0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [3:0] rs,
                                          input logic [3:0] rt, input logic [15:0] imm);
        return {op, rs, rt, 2'b00, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [9:0] tgt);
        return {op, 16'b0, tgt};
    endfunction

    task automatic run(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_imem();
        for (int a = 0; a < 1024; a++) dut.inst_mem.memory[a] = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(1);
        reset = 1'b0;
    endtask

    task automatic check_regs_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_r%0d", tag, i), {16'h0, dut.regs.registers[i]}, 32'h0);
        end
    endtask

    initial begin
        reset = 1'b0;

        // Program A: addi, R-type, immediates, register 0, unknown encodings
        clear_imem();
        dut.inst_mem.memory[0]  = enc_i(6'b001000, 4'd0, 4'd1, 16'd5);
        dut.inst_mem.memory[1]  = enc_i(6'b001000, 4'd1, 4'd2, 16'hFFFD);
        dut.inst_mem.memory[2]  = enc_i(6'b001000, 4'd0, 4'd1, 16'd7);
        dut.inst_mem.memory[3]  = enc_i(6'b001000, 4'd0, 4'd2, 16'd9);
        dut.inst_mem.memory[4]  = enc_r(4'd1, 4'd2, 4'd3, 6'b100010);
        dut.inst_mem.memory[5]  = enc_r(4'd1, 4'd2, 4'd4, 6'b101010);
        dut.inst_mem.memory[6]  = enc_r(4'd1, 4'd2, 4'd5, 6'b100100);
        dut.inst_mem.memory[7]  = enc_r(4'd1, 4'd2, 4'd6, 6'b100101);
        dut.inst_mem.memory[8]  = enc_i(6'b001000, 4'd0, 4'd0, 16'd9);
        dut.inst_mem.memory[9]  = enc_i(6'b001111, 4'd0, 4'd7, 16'h8000);
        dut.inst_mem.memory[10] = enc_r(4'd7, 4'd1, 4'd8, 6'b101010);
        dut.inst_mem.memory[11] = enc_i(6'b001100, 4'd2, 4'd10, 16'h000C);
        dut.inst_mem.memory[12] = enc_i(6'b001101, 4'd2, 4'd11, 16'h00F0);
        dut.inst_mem.memory[13] = enc_i(6'b001010, 4'd2, 4'd12, 16'hFFFF);
        dut.inst_mem.memory[14] = enc_i(6'b001010, 4'd7, 4'd9, 16'd1);
        dut.inst_mem.memory[15] = enc_i(6'b111111, 4'd1, 4'd14, 16'd5);
        dut.inst_mem.memory[16] = enc_r(4'd1, 4'd2, 4'd13, 6'b000000);

        do_reset();
        check("reset_pc", {22'h0, dut.pc}, 32'd0);
        check_regs_zero("reset");

        run(2);
        check("addi_r1", {16'h0, dut.regs.registers[1]}, 32'h0005);
        check("addi_neg_r2", {16'h0, dut.regs.registers[2]}, 32'h0002);
        check("addi_pc", {22'h0, dut.pc}, 32'd2);
        run(2);
        run(4);
        check("sub_r3", {16'h0, dut.regs.registers[3]}, 32'hFFFE);
        check("slt_r4", {16'h0, dut.regs.registers[4]}, 32'h0001);
        check("and_r5", {16'h0, dut.regs.registers[5]}, 32'h0001);
        check("or_r6", {16'h0, dut.regs.registers[6]}, 32'h000F);
        check("rtype_pc", {22'h0, dut.pc}, 32'd8);
        run(1);
        check("r0_write_discarded", {16'h0, dut.regs.registers[0]}, 32'h0);
        run(2);
        check("li_r7", {16'h0, dut.regs.registers[7]}, 32'h8000);
        check("slt_signed_r8", {16'h0, dut.regs.registers[8]}, 32'h0001);
        run(4);
        check("andi_r10", {16'h0, dut.regs.registers[10]}, 32'h0008);
        check("ori_r11", {16'h0, dut.regs.registers[11]}, 32'h00F9);
        check("slti_false_r12", {16'h0, dut.regs.registers[12]}, 32'h0000);
        check("slti_signed_r9", {16'h0, dut.regs.registers[9]}, 32'h0001);
        run(2);
        check("bad_op_r14", {16'h0, dut.regs.registers[14]}, 32'h0);
        check("bad_funct_r13", {16'h0, dut.regs.registers[13]}, 32'h0);
        check("bad_pc", {22'h0, dut.pc}, 32'd17);

        // Program B: sw/lw and branches
        clear_imem();
        dut.inst_mem.memory[0] = enc_i(6'b001111, 4'd0, 4'd1, 16'h1234);
        dut.inst_mem.memory[1] = enc_i(6'b101011, 4'd0, 4'd1, 16'd4);
        dut.inst_mem.memory[2] = enc_i(6'b100011, 4'd0, 4'd5, 16'd4);
        dut.inst_mem.memory[3] = enc_i(6'b000100, 4'd0, 4'd0, 16'd2);
        dut.inst_mem.memory[4] = enc_i(6'b001000, 4'd0, 4'd6, 16'd1);
        dut.inst_mem.memory[5] = enc_i(6'b001000, 4'd0, 4'd6, 16'd2);
        dut.inst_mem.memory[6] = enc_i(6'b000101, 4'd1, 4'd1, 16'd5);
        dut.inst_mem.memory[7] = enc_i(6'b000101, 4'd1, 4'd0, 16'hFFF8);

        do_reset();
        run(1);
        check("li_r1", {16'h0, dut.regs.registers[1]}, 32'h1234);
        run(1);
        check("sw_dmem4", {16'h0, dut.data_mem.memory[4]}, 32'h1234);
        check("sw_no_regwrite", {16'h0, dut.regs.registers[1]}, 32'h1234);
        run(1);
        check("lw_r5", {16'h0, dut.regs.registers[5]}, 32'h1234);
        check("lw_pc", {22'h0, dut.pc}, 32'd3);
        run(1);
        check("beq_taken_pc", {22'h0, dut.pc}, 32'd6);
        run(1);
        check("bne_not_taken_pc", {22'h0, dut.pc}, 32'd7);
        run(1);
        check("bne_back_wrap_pc", {22'h0, dut.pc}, 32'd0);
        check("beq_skipped_r6", {16'h0, dut.regs.registers[6]}, 32'h0);

        // Program C: jal, jr, then reset mid-run
        clear_imem();
        dut.inst_mem.memory[0]  = enc_i(6'b001000, 4'd0, 4'd1, 16'd3);
        dut.inst_mem.memory[1]  = enc_i(6'b001000, 4'd0, 4'd2, 16'd3);
        dut.inst_mem.memory[2]  = enc_i(6'b101011, 4'd0, 4'd1, 16'd8);
        dut.inst_mem.memory[3]  = enc_i(6'b001000, 4'd0, 4'd3, 16'd1);
        dut.inst_mem.memory[4]  = enc_i(6'b001000, 4'd0, 4'd4, 16'd1);
        dut.inst_mem.memory[5]  = enc_j(6'b000011, 10'h020);
        dut.inst_mem.memory[32] = enc_r(4'd15, 4'd0, 4'd0, 6'b001000);
        dut.inst_mem.memory[6]  = enc_i(6'b001000, 4'd0, 4'd6, 16'd4);

        do_reset();
        run(5);
        check("pre_jal_pc", {22'h0, dut.pc}, 32'd5);
        check("sw_dmem8", {16'h0, dut.data_mem.memory[8]}, 32'h0003);
        run(1);
        check("jal_r15", {16'h0, dut.regs.registers[15]}, 32'h0006);
        check("jal_pc", {22'h0, dut.pc}, 32'd32);
        run(1);
        check("jr_pc", {22'h0, dut.pc}, 32'd6);
        check("jr_r15_kept", {16'h0, dut.regs.registers[15]}, 32'h0006);
        run(1);
        check("post_jr_r6", {16'h0, dut.regs.registers[6]}, 32'h0004);
        check("pre_reset_pc", {22'h0, dut.pc}, 32'd7);
        do_reset();
        check("midrun_reset_pc", {22'h0, dut.pc}, 32'd0);
        check_regs_zero("midrun");
        check("midrun_dmem8_kept", {16'h0, dut.data_mem.memory[8]}, 32'h0003);
        check("midrun_dmem4_kept", {16'h0, dut.data_mem.memory[4]}, 32'h1234);

        // Program D: jump to the last word, then pc+1 wraps to 0
        clear_imem();
        dut.inst_mem.memory[0]    = enc_j(6'b000010, 10'h3FF);
        dut.inst_mem.memory[1023] = enc_i(6'b001000, 4'd0, 4'd5, 16'd1);

        do_reset();
        run(1);
        check("j_pc", {22'h0, dut.pc}, 32'd1023);
        run(1);
        check("wrap_pc", {22'h0, dut.pc}, 32'd0);
        check("wrap_r5", {16'h0, dut.regs.registers[5]}, 32'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
